// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and stall encodings for the pipeline hazard controller.
// Every pipeline register decodes the stall code, so its values are fixed here.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned STALL_WIDTH = 2;
  localparam int unsigned REG_IDX_W   = 5;

  localparam logic [STALL_WIDTH-1:0] STALL_NONE   = 2'd0;
  localparam logic [STALL_WIDTH-1:0] STALL_LOAD   = 2'd1;
  localparam logic [STALL_WIDTH-1:0] STALL_BRANCH = 2'd2;
  localparam logic [STALL_WIDTH-1:0] STALL_MEM    = 2'd3;

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StBrFlush
  } hazard_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// The pipeline side is the master; the controller is the slave.
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  logic [REG_IDX_W-1:0]   id_rs1;
  logic [REG_IDX_W-1:0]   id_rs2;
  logic                   id_uses_rs1;
  logic                   id_uses_rs2;
  logic                   ex_valid;
  logic                   ex_is_load;
  logic [REG_IDX_W-1:0]   ex_rd;
  logic                   branch_taken;
  logic                   dmem_req;
  logic                   dmem_ready;
  logic [STALL_WIDTH-1:0] stall;
  logic                   flush_id;
  logic                   flush_ex;
  logic                   mem_timeout;
  logic [31:0]            stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_valid, ex_is_load, ex_rd,
    output branch_taken, dmem_req, dmem_ready,
    input  stall, flush_id, flush_ex, mem_timeout, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_valid, ex_is_load, ex_rd,
    input  branch_taken, dmem_req, dmem_ready,
    output stall, flush_id, flush_ex, mem_timeout, stall_cycles
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between the ID sources and the EX load target.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign hazard = ex_valid && ex_is_load && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, data-memory wait stalls with timeout,
// and wrong-path flushing after taken branches.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [2:0]  FlushLoad  = 3'(FLUSH_CYCLES);
  localparam logic [15:0] TimeoutVal = 16'(MEM_TIMEOUT);

  hazard_state_e          state_q, state_d;
  logic                   pend_br_q, pend_br_d;
  logic [15:0]            wait_q, wait_d;
  logic [2:0]             flush_cnt_q, flush_cnt_d;
  logic                   timeout_q, timeout_d;
  logic [31:0]            stall_cnt_q;

  logic                   load_use;
  logic                   mem_block;
  logic                   mem_done;
  logic [STALL_WIDTH-1:0] stall;
  logic                   flush_id;
  logic                   flush_ex;

  hazard_detect u_hazard_detect (
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_uses_rs1 (bus.id_uses_rs1),
    .id_uses_rs2 (bus.id_uses_rs2),
    .ex_valid    (bus.ex_valid),
    .ex_is_load  (bus.ex_is_load),
    .ex_rd       (bus.ex_rd),
    .hazard      (load_use)
  );

  assign mem_block = bus.dmem_req && !bus.dmem_ready;
  // A timed-out wait is released exactly as if the memory had answered.
  assign mem_done  = bus.dmem_ready || (wait_q >= TimeoutVal);

  always_comb begin
    state_d     = state_q;
    pend_br_d   = pend_br_q;
    wait_d      = wait_q;
    flush_cnt_d = flush_cnt_q;
    timeout_d   = timeout_q;
    stall       = STALL_NONE;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_block) begin
          stall     = STALL_MEM;
          state_d   = StMemWait;
          wait_d    = 16'd1;
          pend_br_d = bus.branch_taken;
        end else if (bus.branch_taken) begin
          flush_id    = 1'b1;
          flush_ex    = 1'b1;
          state_d     = StBrFlush;
          flush_cnt_d = FlushLoad;
        end else if (load_use) begin
          stall    = STALL_LOAD;
          flush_ex = 1'b1;
        end
      end

      StMemWait: begin
        if (mem_done) begin
          timeout_d = timeout_q || !bus.dmem_ready;
          pend_br_d = 1'b0;
          wait_d    = 16'd0;
          if (pend_br_q || bus.branch_taken) begin
            flush_id    = 1'b1;
            flush_ex    = 1'b1;
            state_d     = StBrFlush;
            flush_cnt_d = FlushLoad;
          end else begin
            state_d = StRun;
          end
        end else begin
          stall  = STALL_MEM;
          wait_d = wait_q + 16'd1;
          if (bus.branch_taken) begin
            pend_br_d = 1'b1;
          end
        end
      end

      StBrFlush: begin
        flush_id = 1'b1;
        if (bus.branch_taken) begin
          flush_cnt_d = FlushLoad;
        end else if (flush_cnt_q <= 3'd1) begin
          flush_cnt_d = 3'd0;
          state_d     = StRun;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end

      default: state_d = StRun;
    endcase

    // Reset silences the pipeline controls regardless of state or inputs.
    if (rst) begin
      stall    = STALL_NONE;
      flush_id = 1'b0;
      flush_ex = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      pend_br_q   <= 1'b0;
      wait_q      <= 16'd0;
      flush_cnt_q <= 3'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pend_br_q   <= pend_br_d;
      wait_q      <= wait_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
      if ((stall != STALL_NONE) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.stall        = stall;
  assign bus.flush_id     = flush_id;
  assign bus.flush_ex     = flush_ex;
  assign bus.mem_timeout  = timeout_q;
  assign bus.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  typedef struct {
    logic       rst;
    logic       exv;
    logic       exl;
    logic [4:0] exrd;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       br;
    logic       dreq;
    logic       drdy;
    logic [1:0] e_stall;
    logic       e_fid;
    logic       e_fex;
    logic [31:0] e_sc;
    logic       e_tmo;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic vec_t mk(input int r, input int exv, input int exl, input int exrd,
                              input int rs1, input int u1, input int rs2, input int u2,
                              input int br, input int dreq, input int drdy, input int st,
                              input int fid, input int fex, input int sc, input int tmo);
    vec_t v;
    v.rst = 1'(r);     v.exv = 1'(exv);   v.exl = 1'(exl);   v.exrd = 5'(exrd);
    v.rs1 = 5'(rs1);   v.u1 = 1'(u1);     v.rs2 = 5'(rs2);   v.u2 = 1'(u2);
    v.br = 1'(br);     v.dreq = 1'(dreq); v.drdy = 1'(drdy); v.e_stall = 2'(st);
    v.e_fid = 1'(fid); v.e_fex = 1'(fex); v.e_sc = 32'(sc);  v.e_tmo = 1'(tmo);
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are compared at the negedge.
  task automatic run_vec(input vec_t v, input int idx);
    rst              = v.rst;
    bus.ex_valid     = v.exv;
    bus.ex_is_load   = v.exl;
    bus.ex_rd        = v.exrd;
    bus.id_rs1       = v.rs1;
    bus.id_uses_rs1  = v.u1;
    bus.id_rs2       = v.rs2;
    bus.id_uses_rs2  = v.u2;
    bus.branch_taken = v.br;
    bus.dmem_req     = v.dreq;
    bus.dmem_ready   = v.drdy;
    @(negedge clk);
    check("stall",        idx, 32'(bus.stall),        32'(v.e_stall));
    check("flush_id",     idx, 32'(bus.flush_id),     32'(v.e_fid));
    check("flush_ex",     idx, 32'(bus.flush_ex),     32'(v.e_fex));
    check("stall_cycles", idx, bus.stall_cycles,      v.e_sc);
    check("mem_timeout",  idx, 32'(bus.mem_timeout),  32'(v.e_tmo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           rst exv exl rd rs1 u1 rs2 u2 br dreq drdy  st fid fex  sc tmo
    // Reset dominates even with every hazard source active.
    vecs.push_back(mk(1, 1, 1, 3, 3, 1, 0, 0, 1, 1, 0,   0, 0, 0,  0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0));
    // Load-use on rs1, then the bubble clears it.
    vecs.push_back(mk(0, 1, 1, 5, 5, 1, 0, 0, 0, 0, 0,   1, 0, 1,  0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0,   0, 0, 0,  1, 0));
    // Load into x0 never stalls.
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0,   0, 0, 0,  1, 0));
    // Load-use through rs2 only; then no use flags; then non-load producer.
    vecs.push_back(mk(0, 1, 1, 7, 7, 0, 7, 1, 0, 0, 0,   1, 0, 1,  1, 0));
    vecs.push_back(mk(0, 1, 1, 7, 7, 0, 7, 0, 0, 0, 0,   0, 0, 0,  2, 0));
    vecs.push_back(mk(0, 1, 0, 7, 7, 1, 7, 1, 0, 0, 0,   0, 0, 0,  2, 0));
    // Memory wait: ready low for 4 cycles, then high.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, 2 + i, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0,  6, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  6, 0));
    // Branch taken while waiting on memory: flush both on the ready cycle, then 2 flush_id.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   3, 0, 0,  6, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   3, 0, 0,  7, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   3, 0, 0,  8, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 1, 1,  9, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 0,  9, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0,  9, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  9, 0));
    // Branch beats load-use; a second branch in the flush window reloads the counter.
    vecs.push_back(mk(0, 1, 1, 3, 3, 1, 0, 0, 1, 0, 0,   0, 1, 1,  9, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0,  9, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 1, 0,  9, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0,  9, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0,  9, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  9, 0));
    // Memory stall beats branch and load-use; branch remembered; reset mid-flush.
    vecs.push_back(mk(0, 1, 1, 3, 3, 1, 0, 0, 1, 1, 0,   3, 0, 0,  9, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 1, 1, 10, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 10, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0));
    // Timeout: 8 stall cycles, release, sticky flag, cleared only by reset.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, i, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0,  8, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  8, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  8, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  8, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0));

    @(posedge clk);
    #1;
    foreach (vecs[i]) run_vec(vecs[i], i);

    // Timeout with a pending branch: the release cycle flushes both stages.
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0, 0, 0), 100);
    for (int i = 1; i < 8; i++)
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 0, i, 0), 100 + i);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 8, 0), 108);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8, 1), 109);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8, 1), 110);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 1), 111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
